// File: rtl/pipeline_hazard_controller.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_controller
//
// Hazard unit for a 5-stage MIPS pipeline. It keeps a 3-entry scoreboard that
// shadows the instructions in EX, MEM and WB. Against that scoreboard it
// detects RAW hazards for the instruction currently in ID, squashes wrong-path
// work on a taken branch, and produces the EX-stage forwarding mux selects.
// All control outputs are combinational from scoreboard state and the current
// ID inputs, so the unit adds no latency.
//
// Build option:
//   FORWARDING_EN  defined   -> stall only on load-use (1 cycle); forwarding
//                               selects driven from the MEM/WB entries.
//                  undefined -> stall while an EX or MEM entry writes an ID
//                               source (up to 2 cycles); fwd_a/fwd_b tied 00.
//
// Parameters:
//   REG_ADDR_W   register-file address width
//   PERF_CNT_W   width of the saturating stall/flush counters
//
// Ports:
//   clk, reset       rising-edge clock, asynchronous active-high reset
//   id_valid         ID holds a real instruction
//   id_rs, id_rt     ID source registers
//   id_uses_rs/rt    ID instruction actually reads rs / rt
//   id_reg_write     RegWrite of the ID instruction
//   id_mem_read      MemRead of the ID instruction (loads)
//   id_write_reg     ID destination after the RegDst mux
//   ex_branch_taken  branch in EX resolved taken this cycle
//   pc_write         PC load enable
//   ifid_write       IF/ID load enable
//   ifid_flush       clear IF/ID to NOP
//   idex_bubble      load NOP control into ID/EX
//   fwd_a, fwd_b     EX operand selects: 00 regfile, 10 EX/MEM, 01 MEM/WB
//   stall_cycles     saturating count of stalled cycles
//   flush_cycles     saturating count of flush cycles
// -----------------------------------------------------------------------------
module pipeline_hazard_controller #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned PERF_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic [REG_ADDR_W-1:0] id_write_reg,
    input  logic                  ex_branch_taken,
    output logic                  pc_write,
    output logic                  ifid_write,
    output logic                  ifid_flush,
    output logic                  idex_bubble,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b,
    output logic [PERF_CNT_W-1:0] stall_cycles,
    output logic [PERF_CNT_W-1:0] flush_cycles
);

    typedef struct packed {
        logic                  valid;
        logic                  reg_write;
        logic                  mem_read;
        logic                  uses_rs;
        logic                  uses_rt;
        logic [REG_ADDR_W-1:0] rd;
        logic [REG_ADDR_W-1:0] rs;
        logic [REG_ADDR_W-1:0] rt;
    } sb_entry_t;

    sb_entry_t ex_q, ex_d;
    sb_entry_t mem_q;
    sb_entry_t wb_q;

    logic [PERF_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [PERF_CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic stall_raw;
    logic stall;

    // An entry produces source s only if it is live, writes a register other
    // than $0, targets s, and the consumer actually reads that operand.
    function automatic logic writes_reg(input sb_entry_t e,
                                        input logic [REG_ADDR_W-1:0] s,
                                        input logic uses);
        return uses & e.valid & e.reg_write & (e.rd != '0) & (e.rd == s);
    endfunction

`ifdef FORWARDING_EN
    always_comb begin
        stall_raw = id_valid & ex_q.mem_read &
                    (writes_reg(ex_q, id_rs, id_uses_rs) |
                     writes_reg(ex_q, id_rt, id_uses_rt));
    end

    // MEM is younger than WB, so its result wins for the same register.
    always_comb begin
        fwd_a = 2'b00;
        if (writes_reg(mem_q, ex_q.rs, ex_q.valid & ex_q.uses_rs)) begin
            fwd_a = 2'b10;
        end else if (writes_reg(wb_q, ex_q.rs, ex_q.valid & ex_q.uses_rs)) begin
            fwd_a = 2'b01;
        end
    end

    always_comb begin
        fwd_b = 2'b00;
        if (writes_reg(mem_q, ex_q.rt, ex_q.valid & ex_q.uses_rt)) begin
            fwd_b = 2'b10;
        end else if (writes_reg(wb_q, ex_q.rt, ex_q.valid & ex_q.uses_rt)) begin
            fwd_b = 2'b01;
        end
    end
`else
    // WB never stalls: the register file writes before it is read.
    always_comb begin
        stall_raw = id_valid &
                    (writes_reg(ex_q,  id_rs, id_uses_rs) |
                     writes_reg(ex_q,  id_rt, id_uses_rt) |
                     writes_reg(mem_q, id_rs, id_uses_rs) |
                     writes_reg(mem_q, id_rt, id_uses_rt));
    end

    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
    end
`endif

    // Scoreboard fields that one build does not consume are folded here so
    // both builds keep the same entry layout.
    logic unused_sb_fields;
    assign unused_sb_fields = ^{ex_q, mem_q, wb_q};

    // A taken branch discards the ID instruction anyway, so it masks the stall.
    always_comb begin
        stall       = stall_raw & ~ex_branch_taken;
        pc_write    = ~stall;
        ifid_write  = ~stall;
        ifid_flush  = ex_branch_taken;
        idex_bubble = stall | ex_branch_taken;
    end

    always_comb begin
        ex_d = '0;
        if (id_valid & ~stall & ~ex_branch_taken) begin
            ex_d.valid     = 1'b1;
            ex_d.reg_write = id_reg_write;
            ex_d.mem_read  = id_mem_read;
            ex_d.uses_rs   = id_uses_rs;
            ex_d.uses_rt   = id_uses_rt;
            ex_d.rd        = id_write_reg;
            ex_d.rs        = id_rs;
            ex_d.rt        = id_rt;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (ex_branch_taken && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= ex_q;
            wb_q        <= mem_q;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign flush_cycles = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
module tb_pipeline_hazard_controller;

    logic        clk;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rs;
    logic        id_uses_rt;
    logic        id_reg_write;
    logic        id_mem_read;
    logic [4:0]  id_write_reg;
    logic        ex_branch_taken;
    logic        pc_write;
    logic        ifid_write;
    logic        ifid_flush;
    logic        idex_bubble;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic [15:0] stall_cycles;
    logic [15:0] flush_cycles;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    pipeline_hazard_controller #(
        .REG_ADDR_W (5),
        .PERF_CNT_W (16)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .id_valid        (id_valid),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rs      (id_uses_rs),
        .id_uses_rt      (id_uses_rt),
        .id_reg_write    (id_reg_write),
        .id_mem_read     (id_mem_read),
        .id_write_reg    (id_write_reg),
        .ex_branch_taken (ex_branch_taken),
        .pc_write        (pc_write),
        .ifid_write      (ifid_write),
        .ifid_flush      (ifid_flush),
        .idex_bubble     (idex_bubble),
        .fwd_a           (fwd_a),
        .fwd_b           (fwd_b),
        .stall_cycles    (stall_cycles),
        .flush_cycles    (flush_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // In-flight instructions by age: [0] in EX, [1] in MEM, [2] in WB.
    typedef struct {
        bit          v;
        bit          rw;
        bit          mr;
        bit          urs;
        bit          urt;
        int unsigned rd;
        int unsigned rs;
        int unsigned rt;
    } instr_t;

    instr_t      inflight [3];
    int unsigned m_stall;
    int unsigned m_flush;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit produces(input instr_t p, input int unsigned src, input bit used);
        return used && p.v && p.rw && (p.rd != 0) && (p.rd == src);
    endfunction

    function automatic bit exp_stall();
        bit dep_ex, dep_mem, raw;
        dep_ex  = produces(inflight[0], int'(id_rs), id_uses_rs) ||
                  produces(inflight[0], int'(id_rt), id_uses_rt);
        dep_mem = produces(inflight[1], int'(id_rs), id_uses_rs) ||
                  produces(inflight[1], int'(id_rt), id_uses_rt);
`ifdef FORWARDING_EN
        raw = dep_ex && inflight[0].mr;
`else
        raw = dep_ex || dep_mem;
`endif
        return id_valid && raw && !ex_branch_taken;
    endfunction

    // Youngest older producer wins: MEM (10) before WB (01).
    function automatic logic [1:0] exp_fwd(input int unsigned src, input bit used);
`ifdef FORWARDING_EN
        if (produces(inflight[1], src, used && inflight[0].v)) return 2'b10;
        if (produces(inflight[2], src, used && inflight[0].v)) return 2'b01;
`endif
        return 2'b00;
    endfunction

    task automatic model_check();
        bit st;
        st = exp_stall();
        check_eq("pc_write",     pc_write,    !st);
        check_eq("ifid_write",   ifid_write,  !st);
        check_eq("ifid_flush",   ifid_flush,  ex_branch_taken);
        check_eq("idex_bubble",  idex_bubble, st || ex_branch_taken);
        check_eq("fwd_a",        fwd_a, exp_fwd(inflight[0].rs, inflight[0].urs));
        check_eq("fwd_b",        fwd_b, exp_fwd(inflight[0].rt, inflight[0].urt));
        check_eq("stall_cycles", stall_cycles, m_stall);
        check_eq("flush_cycles", flush_cycles, m_flush);
    endtask

    // Drive ID inputs just after an edge and check mid-cycle.
    task automatic apply(input bit v, input int unsigned rs, input int unsigned rt,
                         input bit urs, input bit urt, input bit rw, input bit mr,
                         input int unsigned wr, input bit br);
        id_valid        = v;
        id_rs           = 5'(rs);
        id_rt           = 5'(rt);
        id_uses_rs      = urs;
        id_uses_rt      = urt;
        id_reg_write    = rw;
        id_mem_read     = mr;
        id_write_reg    = 5'(wr);
        ex_branch_taken = br;
        #4;
        model_check();
    endtask

    task automatic apply_nop();
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Advance the model with the inputs currently held, then cross the edge.
    task automatic advance();
        bit     st;
        instr_t nx;
        st = exp_stall();
        if (st && m_stall < 32'hFFFF) m_stall++;
        if (ex_branch_taken && m_flush < 32'hFFFF) m_flush++;
        nx = '{default: 0};
        if (id_valid && !st && !ex_branch_taken) begin
            nx.v   = 1'b1;
            nx.rw  = id_reg_write;
            nx.mr  = id_mem_read;
            nx.urs = id_uses_rs;
            nx.urt = id_uses_rt;
            nx.rd  = int'(id_write_reg);
            nx.rs  = int'(id_rs);
            nx.rt  = int'(id_rt);
        end
        inflight[2] = inflight[1];
        inflight[1] = inflight[0];
        inflight[0] = nx;
        @(posedge clk);
        #1;
    endtask

    // Asserts reset immediately (possibly mid-cycle), checks reset values
    // while held and one cycle after release; ends 1 time unit after an edge.
    task automatic do_reset();
        reset           = 1'b1;
        id_valid        = 1'b0;
        ex_branch_taken = 1'b0;
        #2;
        check_eq("rst_stall_cnt", stall_cycles, 0);
        check_eq("rst_flush_cnt", flush_cycles, 0);
        check_eq("rst_fwd_a",     fwd_a,        0);
        check_eq("rst_fwd_b",     fwd_b,        0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int unsigned k = 0; k < 3; k++) inflight[k] = '{default: 0};
        m_stall = 0;
        m_flush = 0;
        #2;
        check_eq("post_pc_write",    pc_write,    1);
        check_eq("post_ifid_write",  ifid_write,  1);
        check_eq("post_ifid_flush",  ifid_flush,  0);
        check_eq("post_idex_bubble", idex_bubble, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        instr_t cur;
        bit     hold;
        bit     br;
        bit     flushed;

        reset = 1'b1;
        {id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt} = '0;
        {id_reg_write, id_mem_read, id_write_reg, ex_branch_taken} = '0;
        for (int unsigned k = 0; k < 3; k++) inflight[k] = '{default: 0};
        m_stall = 0;
        m_flush = 0;
        do_reset();

        // ---------- randomized traffic over a small register set ----------
        hold    = 1'b0;
        flushed = 1'b0;
        cur     = '{default: 0};
        for (int unsigned i = 0; i < 3000; i++) begin
            if (!hold) begin
                cur.v   = flushed ? 1'b0 : ($urandom_range(0, 3) != 0);
                cur.rs  = $urandom_range(0, 3);
                cur.rt  = $urandom_range(0, 3);
                cur.urs = $urandom_range(0, 1);
                cur.urt = $urandom_range(0, 1);
                cur.rw  = ($urandom_range(0, 3) != 0);
                cur.mr  = cur.rw && ($urandom_range(0, 1) != 0);
                cur.rd  = $urandom_range(0, 3);
            end
            br = ($urandom_range(0, 9) == 0);
            apply(cur.v, cur.rs, cur.rt, cur.urs, cur.urt, cur.rw, cur.mr, cur.rd, br);
            hold    = exp_stall();
            flushed = br;
            advance();
        end

        // ---------- reset while a load-use stall is active ----------
        apply(1, 9, 0, 1, 0, 1, 1, 8, 0);             // lw $8,0($9)
        advance();
        apply(1, 8, 8, 1, 1, 1, 0, 10, 0);            // add $10,$8,$8
        check_eq("t1_stalling", idex_bubble, 1);
        do_reset();
        apply_nop();
        advance();

`ifdef FORWARDING_EN
        // ---------- EX/MEM forward ----------
        do_reset();
        apply(1, 1, 2, 1, 1, 1, 0, 3, 0);             // add $3,$1,$2
        advance();
        apply(1, 3, 5, 1, 1, 1, 0, 4, 0);             // sub $4,$3,$5
        check_eq("t2_no_stall", pc_write, 1);
        advance();
        apply_nop();
        check_eq("t2_fwd_a", fwd_a, 2'b10);
        advance();

        // ---------- MEM/WB forward ----------
        do_reset();
        apply(1, 1, 2, 1, 1, 1, 0, 3, 0);             // add $3,$1,$2
        advance();
        apply_nop();
        advance();
        apply(1, 3, 3, 1, 1, 1, 0, 6, 0);             // or $6,$3,$3
        advance();
        apply_nop();
        check_eq("t3_fwd_a", fwd_a, 2'b01);
        check_eq("t3_fwd_b", fwd_b, 2'b01);
        advance();

        // ---------- load-use ----------
        do_reset();
        apply(1, 9, 0, 1, 0, 1, 1, 8, 0);             // lw $8,0($9)
        advance();
        apply(1, 8, 8, 1, 1, 1, 0, 10, 0);            // add $10,$8,$8
        check_eq("t4_pc_hold", pc_write, 0);
        check_eq("t4_bubble",  idex_bubble, 1);
        advance();
        apply(1, 8, 8, 1, 1, 1, 0, 10, 0);
        check_eq("t4_issue", pc_write, 1);
        advance();
        apply_nop();
        check_eq("t4_fwd_a", fwd_a, 2'b01);
        check_eq("t4_fwd_b", fwd_b, 2'b01);
        check_eq("t4_stalls", stall_cycles, 1);
        advance();
`else
        // ---------- two-cycle stall without forwarding ----------
        do_reset();
        apply(1, 0, 0, 1, 0, 1, 0, 3, 0);             // addi $3,$0,5
        advance();
        apply(1, 3, 0, 1, 0, 1, 0, 4, 0);             // andi $4,$3,1
        check_eq("t5_stall1", idex_bubble, 1);
        advance();
        apply(1, 3, 0, 1, 0, 1, 0, 4, 0);
        check_eq("t5_stall2", idex_bubble, 1);
        advance();
        apply(1, 3, 0, 1, 0, 1, 0, 4, 0);
        check_eq("t5_issue", pc_write, 1);
        advance();
        apply_nop();
        check_eq("t5_stalls", stall_cycles, 2);
        advance();
`endif

        // ---------- taken branch masks a stall ----------
        do_reset();
        apply(1, 9, 0, 1, 0, 1, 1, 8, 0);             // lw $8,0($9)
        advance();
        apply(1, 8, 8, 1, 1, 1, 0, 10, 1);            // dependent add, beq taken
        check_eq("t6_flush",  ifid_flush,  1);
        check_eq("t6_bubble", idex_bubble, 1);
        check_eq("t6_pc",     pc_write,    1);
        advance();
        apply_nop();
        check_eq("t6_stalls",  stall_cycles, 0);
        check_eq("t6_flushes", flush_cycles, 1);
        advance();

        // ---------- register $0 ----------
        do_reset();
        apply(1, 1, 2, 1, 1, 1, 1, 0, 0);             // lw $0,...
        advance();
        apply(1, 0, 0, 1, 1, 1, 0, 5, 0);             // add $5,$0,$0
        check_eq("z_no_stall", pc_write, 1);
        advance();
        apply_nop();
        check_eq("z_fwd_a", fwd_a, 0);
        check_eq("z_fwd_b", fwd_b, 0);
        advance();

        // ---------- flush counter saturation ----------
        do_reset();
        id_valid        = 1'b0;
        ex_branch_taken = 1'b1;
        for (int unsigned i = 0; i < 65540; i++) advance();
        apply(0, 0, 0, 0, 0, 0, 0, 0, 1);
        check_eq("flush_sat", flush_cycles, 32'hFFFF);
        advance();
        apply(0, 0, 0, 0, 0, 0, 0, 0, 1);
        check_eq("flush_sat_hold", flush_cycles, 32'hFFFF);
        advance();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
